pipe_stage_reg: RTL

- Parametrised inter-stage pipeline register for the five-stage MIPS core with precise exceptions; one instance per boundary (F/D, D/E, E/M, M/W).
- Generalises the fixed-field stage registers: configurable payload width, per-entry valid bit, stall (hold) and flush (bubble) controls, and exception-code merging.
- Sits between the stage logic and the hazard/CP0 control unit.

---
 rtl/pipe_stage_reg.sv | 86 ++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline register with valid/stall/flush and exception merge; PIPE_FLUSH_KEEP_PC_EN keeps PC/BD on flush
module pipe_stage_reg #(
  parameter int PAYLOAD_W = 64,
  parameter int EXC_W = 5,
  parameter int EXC_NONE = 31,
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 valid_in,
  input  logic [31:0]          pc_in,
  input  logic [31:0]          instr_in,
  input  logic [PAYLOAD_W-1:0] data_in,
  input  logic                 we_in,
  input  logic [EXC_W-1:0]     exc_code_in,
  input  logic [EXC_W-1:0]     exc_local,
  input  logic                 bd_in,
  output logic                 valid_out,
  output logic [31:0]          pc_out,
  output logic [31:0]          instr_out,
  output logic [PAYLOAD_W-1:0] data_out,
  output logic                 we_out,
  output logic [EXC_W-1:0]     exc_code_out,
  output logic                 bd_out,
  output logic                 exc_pending
);
  localparam logic [EXC_W-1:0] NONE = EXC_W'(EXC_NONE);
  logic                 valid_d, we_d, bd_d;
  logic [31:0]          pc_d, instr_d;
  logic [PAYLOAD_W-1:0] data_d;
  logic [EXC_W-1:0]     exc_d, merged_exc;
  assign merged_exc  = (exc_code_in != NONE) ? exc_code_in : exc_local;
  assign exc_pending = valid_out && (exc_code_out != NONE);
  always_comb begin
    valid_d = valid_out;
    pc_d    = pc_out;
    instr_d = instr_out;
    data_d  = data_out;
    we_d    = we_out;
    exc_d   = exc_code_out;
    bd_d    = bd_out;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = '0;
      data_d  = '0;
      we_d    = 1'b0;
      exc_d   = NONE;
`ifdef PIPE_FLUSH_KEEP_PC_EN
      pc_d    = stall ? pc_out : pc_in;
      bd_d    = stall ? bd_out : bd_in;
`else
      pc_d    = PC_RESET;
      bd_d    = 1'b0;
`endif
    end else if (!stall) begin
      valid_d = valid_in;
      pc_d    = pc_in;
      bd_d    = bd_in;
      instr_d = valid_in ? instr_in : '0;
      data_d  = valid_in ? data_in : '0;
      we_d    = valid_in && we_in && (merged_exc == NONE);
      exc_d   = valid_in ? merged_exc : NONE;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out    <= 1'b0;
      pc_out       <= PC_RESET;
      instr_out    <= '0;
      data_out     <= '0;
      we_out       <= 1'b0;
      exc_code_out <= NONE;
      bd_out       <= 1'b0;
    end else begin
      valid_out    <= valid_d;
      pc_out       <= pc_d;
      instr_out    <= instr_d;
      data_out     <= data_d;
      we_out       <= we_d;
      exc_code_out <= exc_d;
      bd_out       <= bd_d;
    end
  end
endmodule
